lcd_controller: RTL and testbench
=================================

LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 Parameter P_POWERUP, default 750000: power-up wait in clocks (15 ms at 50 MHz).
REQ-002 Parameter P_T4MS, default 205000: wait after the first init nibble.
REQ-003 Parameter P_T100US, default 5000: wait after the second init nibble.
REQ-004 Parameter P_T40US, default 2000: wait after the third and fourth init nibbles and after each ordinary command or data byte.
REQ-005 Parameter P_T1US, default 50: gap between the high and low nibble of one byte.
REQ-006 Parameter P_TE, default 12: number of clocks oLCD_E is held high per nibble.
REQ-007 Parameter P_TCLR, default 82000: wait after the clear (0x01) and home (0x02) commands.
REQ-008 Port Clock, input, 1: single clock; all logic updates on its rising edge.
REQ-009 Port Reset, input, 1: synchronous, active-low reset.
REQ-010 Port iData, input, 8: byte to send to the LCD.
REQ-011 Port iRS, input, 1: register select for iData; 0 = command, 1 = character.
REQ-012 Port iWrite, input, 1: one-cycle write strobe issued by the CPU LCD instruction.
REQ-013 Port oReady, output, 1: high when the controller can accept an iWrite strobe.
REQ-014 Port oLCD_E, output, 1: LCD enable strobe.
REQ-015 Port oLCD_RS, output, 1: LCD register select.
REQ-016 Port oLCD_RW, output, 1: LCD read/write select; tied to 0 (write only).
REQ-017 Port oLCD_Data, output, 4: LCD data bus, upper four bits (4-bit mode).

Function
REQ-018 FSM states, traversed in this order: POWERUP, INIT_NIB, INIT_CMD, IDLE, SEND_HI, GAP, SEND_LO, SETTLE.
REQ-019 POWERUP: wait P_POWERUP clocks, then enter INIT_NIB.
REQ-020 INIT_NIB sends four single nibbles in sequence, each with RS=0:
- 0x3, then wait P_T4MS;
- 0x3, then wait P_T100US;
- 0x3, then wait P_T40US;
- 0x2, then wait P_T40US.
REQ-021 INIT_CMD sends four full bytes with RS=0, each in two nibbles, in this order: 0x28, 0x06, 0x0C, 0x01.
- The first three are each followed by P_T40US.
- 0x01 is followed by P_TCLR.
- Then enter IDLE.
REQ-022 Nibble strobe timing, applied to every nibble sent:
- cycle 0: oLCD_Data and oLCD_RS valid, oLCD_E=0 (setup);
- cycles 1..P_TE: oLCD_E=1;
- next cycle: oLCD_E=0, data and RS still held.
The wait counting for that nibble starts on this final cycle.
REQ-023 oReady SHALL be 1 only in IDLE, and 0 in every other state.
REQ-024 In IDLE, iWrite=1 captures iData and iRS into internal registers on that edge, and the FSM enters SEND_HI.
REQ-025 SEND_HI strobes iData[7:4], then the FSM enters GAP.
REQ-026 GAP waits P_T1US clocks, then the FSM enters SEND_LO.
REQ-027 SEND_LO strobes iData[3:0], then the FSM enters SETTLE.
REQ-028 SETTLE waits, then the FSM returns to IDLE:
- P_TCLR clocks if the captured iRS=0 and the captured byte is 0x01 or 0x02;
- P_T40US clocks otherwise.
REQ-029 oLCD_RS equals the captured iRS for the whole duration of SEND_HI through SETTLE.
REQ-030 An iWrite strobe while oReady=0 is ignored: no capture, no queueing, no error.
REQ-031 Changes to iData or iRS after capture have no effect on the byte in flight.
REQ-032 There is one shared delay counter, wide enough to hold max(P_POWERUP, P_TCLR).
- It reloads on every state or nibble transition.
- It saturates at zero and never wraps.
REQ-033 When a wait ends and iWrite=1 on the same edge, the write is ignored; it is accepted only once the FSM is in IDLE with oReady=1.

Reset
REQ-034 Reset=0 sampled at a rising edge of Clock puts the FSM in POWERUP and sets, on that edge:
- oReady=0, oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=4'h0;
- delay counter and captured byte cleared.
REQ-035 Reset asserted mid-byte or mid-init aborts the operation immediately, with oLCD_E=0 on that edge. The full power-up and init sequence repeats after Reset returns to 1.
REQ-036 oLCD_RW=0 at all times, including during reset.

Verification
REQ-037 Parameters for simulation: P_POWERUP=20, P_T4MS=10, P_T100US=6, P_T40US=4, P_T1US=2, P_TE=3, P_TCLR=8.
REQ-038 Release reset, no writes -> exactly 12 oLCD_E pulses (nibbles 3,3,3,2,2,8,0,6,0,C,0,1), each 3 cycles wide, all with RS=0; oReady rises after the final wait of 8.
REQ-039 In IDLE, iWrite with iData=0x48, iRS=1 -> oReady falls the next cycle; pulses with data 0x4 then 0x8, RS=1, separated by 2 idle clocks; oReady returns 1 after a 4-clock settle.
REQ-040 In IDLE, iWrite with iData=0x01, iRS=0 -> two pulses (0x0, 0x1), then an 8-clock settle before oReady=1.
REQ-041 iWrite with 0x4F during the SETTLE of the previous byte -> ignored; no extra oLCD_E pulses appear.
REQ-042 Reset=0 while oLCD_E=1 during SEND_LO -> oLCD_E=0 on the next edge; after release the full 12-pulse init sequence repeats.

Source files
------------

// File: rtl/lcd_controller.sv
// HD44780-style character LCD driver in 4-bit write-only mode: runs the power-up/init
// sequence, then sends one CPU byte at a time as two strobed nibbles.
module lcd_controller #(
  parameter int unsigned P_POWERUP = 750000,
  parameter int unsigned P_T4MS    = 205000,
  parameter int unsigned P_T100US  = 5000,
  parameter int unsigned P_T40US   = 2000,
  parameter int unsigned P_T1US    = 50,
  parameter int unsigned P_TE      = 12,
  parameter int unsigned P_TCLR    = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iWrite,
  output logic       oReady,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CntMax = (P_POWERUP > P_TCLR) ? P_POWERUP : P_TCLR;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // Reload values are one less than the wait because the load cycle itself counts.
  localparam logic [CntW-1:0] LdPowerup = CntW'(P_POWERUP - 1);
  localparam logic [CntW-1:0] LdT4ms    = CntW'(P_T4MS - 1);
  localparam logic [CntW-1:0] LdT100us  = CntW'(P_T100US - 1);
  localparam logic [CntW-1:0] LdT40us   = CntW'(P_T40US - 1);
  localparam logic [CntW-1:0] LdT1us    = CntW'(P_T1US - 1);
  localparam logic [CntW-1:0] LdTe      = CntW'(P_TE - 1);
  localparam logic [CntW-1:0] LdTclr    = CntW'(P_TCLR - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StPowerup, StInitNib, StInitCmd, StIdle, StSendHi, StGap, StSendLo, StSettle
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhHigh, PhWait} phase_e;

  state_e          state;
  phase_e          phase;
  logic [CntW-1:0] cnt;
  logic [1:0]      idx;
  logic            lo;
  logic [7:0]      byte_q;
  logic            rs_q;

  logic            cnt_zero;
  logic            sending;
  logic            long_wait;
  logic [1:0]      idx_nxt;
  logic [3:0]      cur_lo;
  logic [3:0]      next_hi;
  logic [CntW-1:0] hold_wait;

  assign oLCD_RW   = 1'b0;
  assign cnt_zero  = (cnt == '0);
  assign idx_nxt   = idx + 2'd1;
  assign sending   = (state == StInitNib) || (state == StInitCmd) ||
                     (state == StSendHi)  || (state == StSendLo);
  assign long_wait = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02));

  // Init command bytes 0x28, 0x06, 0x0C, 0x01: low nibble of the current one and
  // high nibble of the following one (index 3 wraps to 0x28 for the nibble-to-cmd handoff).
  always_comb begin
    cur_lo  = 4'h1;
    next_hi = 4'h2;
    case (idx)
      2'd0: begin cur_lo = 4'h8; next_hi = 4'h0; end
      2'd1: begin cur_lo = 4'h6; next_hi = 4'h0; end
      2'd2: begin cur_lo = 4'hC; next_hi = 4'h0; end
      default: ;
    endcase
  end

  // Wait that follows the nibble now being strobed; its count starts on the E-fall cycle.
  always_comb begin
    hold_wait = LdT40us;
    case (state)
      StInitNib: begin
        if (idx == 2'd0)      hold_wait = LdT4ms;
        else if (idx == 2'd1) hold_wait = LdT100us;
      end
      StInitCmd: begin
        if (!lo)               hold_wait = LdT1us;
        else if (idx == 2'd3)  hold_wait = LdTclr;
      end
      StSendHi: hold_wait = LdT1us;
      StSendLo: if (long_wait) hold_wait = LdTclr;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= StPowerup;
      phase     <= PhSetup;
      cnt       <= '0;
      idx       <= '0;
      lo        <= 1'b0;
      byte_q    <= '0;
      rs_q      <= 1'b0;
      oReady    <= 1'b0;
      oLCD_E    <= 1'b0;
      oLCD_RS   <= 1'b0;
      oLCD_Data <= '0;
    end else begin
      if (!cnt_zero) cnt <= cnt - CntOne;
      if (sending && phase == PhSetup) begin
        phase  <= PhHigh;
        oLCD_E <= 1'b1;
        cnt    <= LdTe;
      end else if (sending && phase == PhHigh) begin
        if (cnt_zero) begin
          oLCD_E <= 1'b0;
          phase  <= PhWait;
          cnt    <= hold_wait;
          if (state == StSendHi)      state <= StGap;
          else if (state == StSendLo) state <= StSettle;
        end
      end else begin
        case (state)
          StPowerup: begin
            // Counter comes out of reset cleared, so the first cycle arms it.
            if (phase == PhSetup) begin
              phase <= PhWait;
              cnt   <= LdPowerup;
            end else if (cnt_zero) begin
              state     <= StInitNib;
              phase     <= PhSetup;
              idx       <= '0;
              oLCD_RS   <= 1'b0;
              oLCD_Data <= 4'h3;
            end
          end
          StInitNib: begin
            if (cnt_zero) begin
              phase <= PhSetup;
              idx   <= idx_nxt;
              if (idx == 2'd3) begin
                state     <= StInitCmd;
                lo        <= 1'b0;
                oLCD_Data <= next_hi;
              end else begin
                oLCD_Data <= (idx == 2'd2) ? 4'h2 : 4'h3;
              end
            end
          end
          StInitCmd: begin
            if (cnt_zero) begin
              if (!lo) begin
                lo        <= 1'b1;
                phase     <= PhSetup;
                oLCD_Data <= cur_lo;
              end else if (idx == 2'd3) begin
                state  <= StIdle;
                oReady <= 1'b1;
              end else begin
                idx       <= idx_nxt;
                lo        <= 1'b0;
                phase     <= PhSetup;
                oLCD_Data <= next_hi;
              end
            end
          end
          StIdle: begin
            if (iWrite) begin
              byte_q    <= iData;
              rs_q      <= iRS;
              oLCD_Data <= iData[7:4];
              oLCD_RS   <= iRS;
              oReady    <= 1'b0;
              state     <= StSendHi;
              phase     <= PhSetup;
            end
          end
          StGap: begin
            if (cnt_zero) begin
              state     <= StSendLo;
              phase     <= PhSetup;
              oLCD_Data <= byte_q[3:0];
            end
          end
          StSettle: begin
            if (cnt_zero) begin
              state  <= StIdle;
              oReady <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with shortened timing parameters; outputs are
// sampled on the falling clock edge.
module tb_lcd_controller;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iWrite;
  logic       oReady;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  int checks = 0;
  int errors = 0;

  lcd_controller #(
    .P_POWERUP(20), .P_T4MS(10), .P_T100US(6), .P_T40US(4),
    .P_T1US(2), .P_TE(3), .P_TCLR(8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iData    (iData),
    .iRS      (iRS),
    .iWrite   (iWrite),
    .oReady   (oReady),
    .oLCD_E   (oLCD_E),
    .oLCD_RS  (oLCD_RS),
    .oLCD_RW  (oLCD_RW),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts E-low cycles up to the next pulse, then captures its data, RS and width.
  task automatic get_pulse(input int budget, output logic ok, output logic [3:0] d,
                           output logic rs, output int w, output int gap);
    gap = 0; w = 0; d = '0; rs = 1'b0; ok = 1'b0;
    while (oLCD_E !== 1'b1 && gap < budget) begin
      gap++;
      @(negedge Clock);
    end
    if (oLCD_E === 1'b1) begin
      ok = 1'b1;
      d  = oLCD_Data;
      rs = oLCD_RS;
      while (oLCD_E === 1'b1 && w < 64) begin
        w++;
        @(negedge Clock);
      end
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (oReady !== 1'b1 && n < budget) begin
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic run_init();
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
    int exp_gap [12] = '{0, 11, 7, 5, 5, 3, 5, 3, 5, 3, 5, 3};
    logic ok, rs;
    logic [3:0] d;
    int w, gap, n;
    for (int k = 0; k < 12; k++) begin
      get_pulse(200, ok, d, rs, w, gap);
      chk($sformatf("init_pulse%0d_seen", k), ok, 1);
      if (ok) begin
        chk($sformatf("init_pulse%0d_data", k), d, exp_nib[k]);
        chk($sformatf("init_pulse%0d_rs", k), rs, 0);
        chk($sformatf("init_pulse%0d_width", k), w, 3);
        if (k > 0) chk($sformatf("init_pulse%0d_gap", k), gap, exp_gap[k]);
      end
    end
    wait_ready(100, n);
    chk("init_final_wait", n, 8);
    chk("init_ready", oReady, 1);
  endtask

  initial begin
    logic ok, rs;
    logic [3:0] d;
    int w, gap, n, e_seen, rdy_low;

    Reset = 1'b0; iWrite = 1'b0; iData = 8'h00; iRS = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_ready", oReady, 0);
    chk("rst_e", oLCD_E, 0);
    chk("rst_rs", oLCD_RS, 0);
    chk("rst_rw", oLCD_RW, 0);
    chk("rst_data", oLCD_Data, 0);

    Reset = 1'b1;
    run_init();

    // Character byte 0x48; inputs are scrambled right after capture.
    iData = 8'h48; iRS = 1'b1; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0; iData = 8'hFF; iRS = 1'b0;
    chk("b48_ready_fall", oReady, 0);
    chk("b48_setup_e", oLCD_E, 0);
    chk("b48_setup_data", oLCD_Data, 4'h4);
    chk("b48_setup_rs", oLCD_RS, 1);
    get_pulse(50, ok, d, rs, w, gap);
    chk("b48_hi_data", d, 4'h4);
    chk("b48_hi_rs", rs, 1);
    chk("b48_hi_width", w, 3);
    get_pulse(50, ok, d, rs, w, gap);
    chk("b48_lo_gap", gap, 3);
    chk("b48_lo_data", d, 4'h8);
    chk("b48_lo_rs", rs, 1);
    chk("b48_lo_width", w, 3);
    chk("b48_hold_data", oLCD_Data, 4'h8);
    chk("b48_hold_rs", oLCD_RS, 1);
    wait_ready(50, n);
    chk("b48_settle", n, 4);
    chk("rw_low", oLCD_RW, 0);

    // Clear command 0x01 takes the long settle.
    iData = 8'h01; iRS = 1'b0; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    get_pulse(50, ok, d, rs, w, gap);
    chk("b01_hi_data", d, 4'h0);
    chk("b01_hi_rs", rs, 0);
    get_pulse(50, ok, d, rs, w, gap);
    chk("b01_lo_data", d, 4'h1);
    chk("b01_lo_width", w, 3);

    // Writes in the first and last settle cycles must both be dropped.
    chk("settle1_ready", oReady, 0);
    iData = 8'h4F; iRS = 1'b1; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    repeat (6) @(negedge Clock);
    chk("settle8_ready", oReady, 0);
    iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    chk("after_settle_ready", oReady, 1);
    e_seen = 0; rdy_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (oLCD_E === 1'b1) e_seen++;
      if (oReady !== 1'b1) rdy_low++;
      @(negedge Clock);
    end
    chk("ignored_no_pulse", e_seen, 0);
    chk("ignored_ready_held", rdy_low, 0);

    // Reset while E is high on the low nibble aborts and restarts the init sequence.
    iData = 8'h48; iRS = 1'b1; iWrite = 1'b1;
    @(negedge Clock);
    iWrite = 1'b0;
    get_pulse(50, ok, d, rs, w, gap);
    n = 0;
    while (oLCD_E !== 1'b1 && n < 20) begin
      n++;
      @(negedge Clock);
    end
    chk("lo_e_high_before_rst", oLCD_E, 1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("midrst_e", oLCD_E, 0);
    chk("midrst_ready", oReady, 0);
    chk("midrst_rs", oLCD_RS, 0);
    chk("midrst_data", oLCD_Data, 0);
    chk("midrst_rw", oLCD_RW, 0);
    @(negedge Clock);
    Reset = 1'b1;
    run_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
